// File: rtl/l2_line_responder_if.sv
// Line-fill bus between an L1-I requester, the L2 line responder and backing memory.
// master: requester/memory side; slave: the responder itself.
interface l2_line_responder_if;
    logic [63:0]  S_R_ADDR;
    logic         S_R_ADDR_VALID;
    logic [511:0] S_R_DATA;
    logic         S_R_DATA_VALID;
    logic [63:0]  M_R_ADDR;
    logic         M_R_ADDR_VALID;
    logic [63:0]  M_R_DATA;
    logic         M_R_DATA_VALID;

    modport master (
        output S_R_ADDR, S_R_ADDR_VALID, M_R_DATA, M_R_DATA_VALID,
        input  S_R_DATA, S_R_DATA_VALID, M_R_ADDR, M_R_ADDR_VALID
    );

    modport slave (
        input  S_R_ADDR, S_R_ADDR_VALID, M_R_DATA, M_R_DATA_VALID,
        output S_R_DATA, S_R_DATA_VALID, M_R_ADDR, M_R_ADDR_VALID
    );
endinterface

// File: rtl/l2_line_responder.sv
// Direct-mapped, read-only L2 that answers 64-byte line fills, refilling from memory in 8 beats.
// Define L2_LINE_RESPONDER_STATS_EN to add HIT_COUNT / MISS_COUNT outputs.
module l2_line_responder #(
    parameter int LINE_COUNT     = 256,
    parameter int BYTES_PER_LINE = 64,
    parameter int HIT_LATENCY    = 2
) (
    input  logic              clk,
    input  logic              reset,
    l2_line_responder_if.slave bus
`ifdef L2_LINE_RESPONDER_STATS_EN
    ,
    output logic [31:0]       HIT_COUNT,
    output logic [31:0]       MISS_COUNT
`endif
);

    localparam int LINE_BITS = BYTES_PER_LINE * 8;
    localparam int BEAT_BITS = 64;
    localparam int IDX_W     = $clog2(LINE_COUNT);
    localparam int TAG_W     = 58 - IDX_W;
    localparam int WAIT_W    = $clog2(HIT_LATENCY + 1);
    // LOOKUP and RESPOND each take one cycle, so HIT_WAIT covers the remainder.
    localparam logic [WAIT_W-1:0] WAIT_INIT =
        (HIT_LATENCY >= 2) ? WAIT_W'(HIT_LATENCY - 2) : '0;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        HIT_WAIT,
        MEM_REQ,
        MEM_FILL,
        RESPOND
    } state_t;

    state_t                        state;
    logic [63:0]                   addr_q;
    logic [2:0]                    beat_cnt;
    logic [WAIT_W-1:0]             wait_cnt;
    logic [LINE_BITS-BEAT_BITS-1:0] fill_buf;
    logic [LINE_BITS-1:0]          s_data_q;
    logic                          s_valid_q;
    logic [63:0]                   m_addr_q;
    logic                          m_valid_q;

    logic [LINE_BITS-1:0]          data_mem [LINE_COUNT];
    logic [TAG_W-1:0]              tag_mem  [LINE_COUNT];
    logic [LINE_COUNT-1:0]         valid_bits;

    logic [IDX_W-1:0]              idx;
    logic [TAG_W-1:0]              tag;
    logic                          lookup_hit;
    logic                          fill_we;
    logic [LINE_BITS-1:0]          fill_line;

    assign idx        = addr_q[6 +: IDX_W];
    assign tag        = addr_q[63 -: TAG_W];
    assign lookup_hit = valid_bits[idx] && (tag_mem[idx] == tag);
    // The final beat goes straight into the array and the response register.
    assign fill_line  = {bus.M_R_DATA, fill_buf};
    assign fill_we    = !reset && (state == MEM_FILL) && bus.M_R_DATA_VALID && (beat_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[idx] <= fill_line;
            tag_mem[idx]  <= tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            fill_buf   <= '0;
            valid_bits <= '0;
            s_data_q   <= '0;
            s_valid_q  <= 1'b0;
            m_addr_q   <= '0;
            m_valid_q  <= 1'b0;
`ifdef L2_LINE_RESPONDER_STATS_EN
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
`endif
        end else begin
            // Response and memory request are single-cycle pulses with zeroed payload otherwise.
            s_data_q  <= '0;
            s_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.S_R_ADDR_VALID) begin
                        addr_q <= bus.S_R_ADDR;
                        state  <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (lookup_hit) begin
`ifdef L2_LINE_RESPONDER_STATS_EN
                        HIT_COUNT <= HIT_COUNT + 32'd1;
`endif
                        if (HIT_LATENCY == 1) begin
                            s_data_q  <= data_mem[idx];
                            s_valid_q <= 1'b1;
                            state     <= RESPOND;
                        end else begin
                            wait_cnt <= WAIT_INIT;
                            state    <= HIT_WAIT;
                        end
                    end else begin
`ifdef L2_LINE_RESPONDER_STATS_EN
                        MISS_COUNT <= MISS_COUNT + 32'd1;
`endif
                        m_addr_q  <= addr_q & ~64'h3F;
                        m_valid_q <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= MEM_REQ;
                    end
                end

                HIT_WAIT: begin
                    if (wait_cnt == '0) begin
                        s_data_q  <= data_mem[idx];
                        s_valid_q <= 1'b1;
                        state     <= RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                MEM_REQ: begin
                    state <= MEM_FILL;
                end

                MEM_FILL: begin
                    if (bus.M_R_DATA_VALID) begin
                        beat_cnt <= beat_cnt + 3'd1;
                        if (beat_cnt == 3'd7) begin
                            valid_bits[idx] <= 1'b1;
                            s_data_q        <= fill_line;
                            s_valid_q       <= 1'b1;
                            state           <= RESPOND;
                        end else begin
                            fill_buf[{beat_cnt, 6'b000000} +: BEAT_BITS] <= bus.M_R_DATA;
                        end
                    end
                end

                RESPOND: begin
                    // Requester may still hold VALID here; only a request seen in IDLE is new.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.S_R_DATA       = s_data_q;
    assign bus.S_R_DATA_VALID = s_valid_q;
    assign bus.M_R_ADDR       = m_addr_q;
    assign bus.M_R_ADDR_VALID = m_valid_q;

endmodule

// File: tb/tb_l2_line_responder.sv
// Directed bench for l2_line_responder: cold miss, hits, conflicts, gapped beats, reset mid-fill.
module tb_l2_line_responder;

    localparam int HIT_LATENCY = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int assertCount = 0;
    int failCount   = 0;
    int respPulses  = 0;
    int memPulses   = 0;

    l2_line_responder_if bus();

`ifdef L2_LINE_RESPONDER_STATS_EN
    logic [31:0] hitCount;
    logic [31:0] missCount;
`endif

    l2_line_responder #(
        .LINE_COUNT     (256),
        .BYTES_PER_LINE (64),
        .HIT_LATENCY    (HIT_LATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef L2_LINE_RESPONDER_STATS_EN
        ,
        .HIT_COUNT  (hitCount),
        .MISS_COUNT (missCount)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.S_R_DATA_VALID === 1'b1) respPulses++;
        if (bus.M_R_ADDR_VALID === 1'b1) memPulses++;
    end

    function automatic logic [511:0] makeLine(input logic [63:0] base);
        logic [511:0] line;
        line = '0;
        for (int k = 0; k < 8; k++) line[k*64 +: 64] = base + 64'(k);
        return line;
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] addr, input logic valid);
        bus.S_R_ADDR       = addr;
        bus.S_R_ADDR_VALID = valid;
    endtask

    task automatic requestMiss(input logic [63:0] addr, input string tag);
        int cycles = 0;
        applyStimulus(addr, 1'b1);
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.M_R_ADDR_VALID !== 1'b1 && cycles < 20);
        checkOutput({tag, "_memreq_delay"}, 512'(cycles), 512'(2));
        checkOutput({tag, "_memreq_addr"}, 512'(bus.M_R_ADDR), 512'(addr & ~64'h3F));
        @(negedge clk);
        checkOutput({tag, "_memreq_pulse"}, 512'(bus.M_R_ADDR_VALID), 512'(0));
    endtask

    task automatic sendBeats(input logic [63:0] base, input int first, input int last, input int gap);
        for (int k = first; k <= last; k++) begin
            bus.M_R_DATA       = base + 64'(k);
            bus.M_R_DATA_VALID = 1'b1;
            @(negedge clk);
            bus.M_R_DATA_VALID = 1'b0;
            if (k != last) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic missTransaction(input logic [63:0] addr, input logic [63:0] base, input int gap, input string tag);
        int r0 = respPulses;
        int m0 = memPulses;
        requestMiss(addr, tag);
        sendBeats(base, 0, 7, gap);
        checkOutput({tag, "_resp_valid"}, 512'(bus.S_R_DATA_VALID), 512'(1));
        checkOutput({tag, "_resp_data"}, bus.S_R_DATA, makeLine(base));
        applyStimulus(64'h0, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_resp_pulse"}, 512'(bus.S_R_DATA_VALID), 512'(0));
        checkOutput({tag, "_data_idle"}, bus.S_R_DATA, 512'(0));
        checkOutput({tag, "_resp_count"}, 512'(respPulses - r0), 512'(1));
        checkOutput({tag, "_mem_count"}, 512'(memPulses - m0), 512'(1));
    endtask

    task automatic hitTransaction(input logic [63:0] addr, input logic [511:0] expLine, input bit holdExtra, input string tag);
        int r0 = respPulses;
        int m0 = memPulses;
        int cycles = 0;
        applyStimulus(addr, 1'b1);
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.S_R_DATA_VALID !== 1'b1 && cycles < 20);
        // Count includes the accepting edge, so the response lands HIT_LATENCY edges after it.
        checkOutput({tag, "_latency"}, 512'(cycles), 512'(HIT_LATENCY + 1));
        checkOutput({tag, "_data"}, bus.S_R_DATA, expLine);
        if (holdExtra) begin
            @(negedge clk);
            checkOutput({tag, "_held_idle"}, 512'(bus.S_R_DATA_VALID), 512'(0));
        end
        applyStimulus(64'h0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput({tag, "_resp_count"}, 512'(respPulses - r0), 512'(1));
        checkOutput({tag, "_no_memreq"}, 512'(memPulses - m0), 512'(0));
    endtask

    initial begin
        int r0;
        int m0;
        bus.S_R_ADDR       = '0;
        bus.S_R_ADDR_VALID = 1'b0;
        bus.M_R_DATA       = '0;
        bus.M_R_DATA_VALID = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_s_valid", 512'(bus.S_R_DATA_VALID), 512'(0));
        checkOutput("rst_s_data", bus.S_R_DATA, 512'(0));
        checkOutput("rst_m_valid", 512'(bus.M_R_ADDR_VALID), 512'(0));
        checkOutput("rst_m_addr", 512'(bus.M_R_ADDR), 512'(0));
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_s_valid", 512'(bus.S_R_DATA_VALID), 512'(0));
        checkOutput("post_rst_m_valid", 512'(bus.M_R_ADDR_VALID), 512'(0));

        $display("[TB] cold miss and hits");
        missTransaction(64'h1040, 64'h0, 0, "cold");
        hitTransaction(64'h1078, makeLine(64'h0), 1'b0, "hit");
        hitTransaction(64'h1040, makeLine(64'h0), 1'b1, "hit_hold");
`ifdef L2_LINE_RESPONDER_STATS_EN
        checkOutput("stats_hits", 512'(hitCount), 512'(2));
        checkOutput("stats_misses", 512'(missCount), 512'(1));
`endif

        $display("[TB] conflict on shared index");
        missTransaction(64'h5040, 64'h5000, 0, "conflict_new");
        missTransaction(64'h1040, 64'h1100, 0, "conflict_old");

        $display("[TB] gapped beats");
        missTransaction(64'h3000, 64'hA5A5_0000_0000_0100, 3, "gapped");
        hitTransaction(64'h3020, makeLine(64'hA5A5_0000_0000_0100), 1'b0, "gapped_hit");

        $display("[TB] reset mid-fill");
        r0 = respPulses;
        m0 = memPulses;
        requestMiss(64'h2000, "rst_fill");
        sendBeats(64'h2000, 0, 4, 0);
        reset = 1'b1;
        applyStimulus(64'h0, 1'b0);
        @(negedge clk);
        checkOutput("midrst_s_valid", 512'(bus.S_R_DATA_VALID), 512'(0));
        checkOutput("midrst_s_data", bus.S_R_DATA, 512'(0));
        checkOutput("midrst_m_valid", 512'(bus.M_R_ADDR_VALID), 512'(0));
        checkOutput("midrst_m_addr", 512'(bus.M_R_ADDR), 512'(0));
        reset = 1'b0;
        sendBeats(64'h2000, 5, 7, 1);
        repeat (3) @(negedge clk);
        checkOutput("stray_no_resp", 512'(respPulses - r0), 512'(0));
        checkOutput("stray_no_memreq", 512'(memPulses - m0), 512'(1));
`ifdef L2_LINE_RESPONDER_STATS_EN
        checkOutput("stats_rst_hits", 512'(hitCount), 512'(0));
        checkOutput("stats_rst_misses", 512'(missCount), 512'(0));
`endif
        missTransaction(64'h2000, 64'h2200, 0, "after_rst");
        missTransaction(64'h1040, 64'h7700, 0, "after_rst_cold");
        hitTransaction(64'h2010, makeLine(64'h2200), 1'b0, "after_rst_hit");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/l2_line_responder.md
L2_LINE_RESPONDER -- requirements
Module: l2_line_responder

Interface
REQ-001 SHALL have parameter LINE_COUNT, default 256, number of direct-mapped lines (power of 2).
REQ-002 SHALL have parameter BYTES_PER_LINE, default 64, fixed at 64; line = 512 bits = 8 memory beats.
REQ-003 SHALL have parameter HIT_LATENCY, default 2, cycles from request acceptance to response on hit (>=1).
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port S_R_ADDR  input  64  line-fill address from L1-I; low 6 offset bits ignored.
REQ-007 SHALL have port S_R_ADDR_VALID  input  1  request valid; requester holds ADDR/VALID stable until S_R_DATA_VALID.
REQ-008 SHALL have port S_R_DATA  output  512  returned line, byte 0 in bits [7:0].
REQ-009 SHALL have port S_R_DATA_VALID  output  1  one-cycle pulse; S_R_DATA valid in that cycle.
REQ-010 SHALL have port M_R_ADDR  output  64  memory line base address, low 6 bits zero.
REQ-011 SHALL have port M_R_ADDR_VALID  output  1  one-cycle memory read request pulse.
REQ-012 SHALL have port M_R_DATA  input  64  memory read beat.
REQ-013 SHALL have port M_R_DATA_VALID  input  1  beat valid; exactly 8 beats per request, gaps allowed.

Function
REQ-014 SHALL implement states IDLE, LOOKUP, HIT_WAIT, MEM_REQ, MEM_FILL, RESPOND.
REQ-015 SHALL, in IDLE with S_R_ADDR_VALID=1, latch S_R_ADDR and go to LOOKUP; otherwise stay in IDLE.
REQ-016 SHALL, in LOOKUP, compare latched tag with stored tag and valid bit of latched index; hit -> HIT_WAIT, miss -> MEM_REQ.
REQ-017 SHALL count HIT_WAIT so S_R_DATA_VALID rises exactly HIT_LATENCY cycles after the accepting IDLE cycle (HIT_LATENCY=1 -> RESPOND directly from LOOKUP).
REQ-018 SHALL, in MEM_REQ, drive M_R_ADDR = latched address with bits [5:0] cleared and M_R_ADDR_VALID=1 for one cycle, then enter MEM_FILL.
REQ-019 SHALL, in MEM_FILL, write the k-th beat (k=0..7, 3-bit counter) into line bits [64k+63:64k]; ignore cycles with M_R_DATA_VALID=0.
REQ-020 SHALL, on beat 7, write data, tag and valid=1 into the indexed line and enter RESPOND next cycle.
REQ-021 SHALL, in RESPOND, assert S_R_DATA_VALID=1 for exactly one cycle with the indexed line on S_R_DATA, then return to IDLE.
REQ-022 SHALL not treat S_R_ADDR_VALID during RESPOND as a new request; a request seen in the following IDLE cycle is new.
REQ-023 SHALL ignore M_R_DATA_VALID outside MEM_FILL.
REQ-024 SHALL drive S_R_DATA to zero whenever S_R_DATA_VALID=0.
REQ-025 SHALL on a miss replace the indexed line unconditionally (read-only, no writeback).

Reset
REQ-026 SHALL, with reset=1 at a clock edge, set state IDLE, clear all valid bits, beat counter and latched address, regardless of current state.
REQ-027 SHALL hold S_R_DATA_VALID=0, S_R_DATA=0, M_R_ADDR_VALID=0, M_R_ADDR=0 during and after reset until a new request.
REQ-028 SHALL discard any in-flight fill on reset; beats arriving after reset are ignored.

Configuration
REQ-029 SHALL, with macro L2_LINE_RESPONDER_STATS_EN defined, add outputs HIT_COUNT and MISS_COUNT (32 bits each, reset 0, incremented in LOOKUP, wrap at 2^32-1 to 0).
REQ-030 SHALL, without L2_LINE_RESPONDER_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-031 SHALL cover cold miss: reset, request 0x1040 -> one M_R_ADDR_VALID pulse with M_R_ADDR=0x1040, 8 beats 0x0..0x7 -> S_R_DATA_VALID one cycle later with word k = k.
REQ-032 SHALL cover hit: repeat 0x1078 after fill -> no memory request, S_R_DATA_VALID exactly 2 cycles after acceptance, same line data.
REQ-033 SHALL cover conflict: request 0x1040 then 0x5040 (same index, LINE_COUNT=256) -> second misses, memory read at 0x5040, subsequent 0x1040 misses again.
REQ-034 SHALL cover gapped beats: 8 beats with 3 idle cycles between each -> correct assembly, response one cycle after beat 7.
REQ-035 SHALL cover reset mid-fill: reset after beat 4 of 0x2000 -> idle outputs, stray beats ignored, next request 0x2000 misses.
REQ-036 SHALL cover stats build: miss then two hits -> HIT_COUNT=2, MISS_COUNT=1.
